// File: rtl/f_register_file_sb.sv
// f_register_file_sb: floating-point register file for the FPU.
// Provides NRD combinational read ports and one writeback port.
// Each register has a pending bit that tracks multi-cycle ops in flight.
// Also holds the sticky fflags accumulator and the frm CSR, and resolves
// the effective rounding mode.
// Optional same-cycle write-to-read forwarding is enabled by defining
// the macro F_REGISTER_FILE_BYPASS_EN. With the macro undefined, a read
// sees the value stored before the write.
module f_register_file_sb #(
    parameter int FLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 3,
    localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    f_rs_addr,
    output logic [NRD*FLEN-1:0]  f_rs_data,
    output logic [NRD-1:0]       f_rs_busy,
    input  logic                 f_wen,
    input  logic [AW-1:0]        f_rd,
    input  logic [FLEN-1:0]      f_w_data,
    input  logic                 f_flags_en,
    input  logic [4:0]           f_w_flags,
    input  logic                 f_issue_en,
    input  logic [AW-1:0]        f_issue_rd,
    input  logic                 csr_fflags_wen,
    input  logic [4:0]           csr_fflags_wdata,
    input  logic                 csr_frm_wen,
    input  logic [2:0]           csr_frm_wdata,
    input  logic [2:0]           insn_rm,
    output logic [2:0]           f_frm,
    output logic [4:0]           f_flags,
    output logic [2:0]           eff_rm,
    output logic                 rm_illegal,
    output logic                 busy_any
);

    // Register count widened by one bit, so that it can be compared with an address
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    logic [FLEN-1:0]     regs_r [NREG];
    logic [NREG-1:0]     pending_r;
    logic [2:0]          frm_r;
    logic [4:0]          flags_r;
    logic [NRD*FLEN-1:0] rs_data_s;
    logic [NRD-1:0]      rs_busy_s;
    logic [2:0]          eff_rm_s;

    // An address is valid only if it names an implemented register.
    // This matters when NREG is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_W);
    endfunction

    // Register array: a writeback updates only the register whose index matches f_rd.
    // An out-of-range index matches no register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (f_wen && (f_rd == AW'(i))) begin
                    regs_r[i] <= f_w_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Pending scoreboard: an issue sets the bit and a writeback clears it.
    // When both target the same register in one cycle, the issue wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (f_issue_en && (f_issue_rd == AW'(i))) begin
                    pending_r[i] <= 1'b1;
                end else if (f_wen && (f_rd == AW'(i))) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Sticky fflags: hardware-accrued bits are ORed in on top of any same-cycle CSR write
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= 5'b00000;
        end else begin
            flags_r <= (csr_fflags_wen ? csr_fflags_wdata : flags_r)
                     | (f_flags_en ? f_w_flags : 5'b00000);
        end
    end

    // frm CSR: stores all eight encodings exactly as written
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_r <= 3'b000;
        end else if (csr_frm_wen) begin
            frm_r <= csr_frm_wdata;
        end else begin
            frm_r <= frm_r;
        end
    end

    // Read ports: every port uses identical mux logic.
    // Busy always reflects the registered pending state and is never forwarded.
    always_comb begin
        rs_data_s = '0;
        rs_busy_s = '0;
        for (int p = 0; p < NRD; p++) begin
`ifdef F_REGISTER_FILE_BYPASS_EN
            if (f_wen && addr_ok(f_rd) && (f_rs_addr[p*AW +: AW] == f_rd)) begin
                rs_data_s[p*FLEN +: FLEN] = f_w_data;
            end else if (addr_ok(f_rs_addr[p*AW +: AW])) begin
                rs_data_s[p*FLEN +: FLEN] = regs_r[f_rs_addr[p*AW +: AW]];
            end else begin
                rs_data_s[p*FLEN +: FLEN] = '0;
            end
`else
            if (addr_ok(f_rs_addr[p*AW +: AW])) begin
                rs_data_s[p*FLEN +: FLEN] = regs_r[f_rs_addr[p*AW +: AW]];
            end else begin
                rs_data_s[p*FLEN +: FLEN] = '0;
            end
`endif
            if (addr_ok(f_rs_addr[p*AW +: AW])) begin
                rs_busy_s[p] = pending_r[f_rs_addr[p*AW +: AW]];
            end else begin
                rs_busy_s[p] = 1'b0;
            end
        end
    end

    // Rounding-mode resolution: a dynamic rm (3'b111) selects frm
    always_comb begin
        eff_rm_s = 3'b000;
        if (insn_rm == 3'b111) begin
            eff_rm_s = frm_r;
        end else begin
            eff_rm_s = insn_rm;
        end
    end

    assign f_rs_data  = rs_data_s;
    assign f_rs_busy  = rs_busy_s;
    assign f_frm      = frm_r;
    assign f_flags    = flags_r;
    assign eff_rm     = eff_rm_s;
    assign rm_illegal = (eff_rm_s == 3'd5) | (eff_rm_s == 3'd6) | (eff_rm_s == 3'd7);
    assign busy_any   = |pending_r;

endmodule

// File: tb/tb_f_register_file_sb.sv
// Testbench for f_register_file_sb.
// Instances under test:
//   - default configuration (FLEN=32, NREG=32, NRD=3);
//   - a 64-bit, 2-port configuration;
//   - a 20-register configuration, used to exercise out-of-range addresses.
// Expected values are queued when stimulus is driven and compared once the outputs settle.
module tb_f_register_file_sb;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3*AW-1:0] f_rs_addr;
    logic [95:0]     f_rs_data;
    logic [2:0]      f_rs_busy;
    logic            f_wen;
    logic [AW-1:0]   f_rd;
    logic [31:0]     f_w_data;
    logic            f_flags_en;
    logic [4:0]      f_w_flags;
    logic            f_issue_en;
    logic [AW-1:0]   f_issue_rd;
    logic            csr_fflags_wen;
    logic [4:0]      csr_fflags_wdata;
    logic            csr_frm_wen;
    logic [2:0]      csr_frm_wdata;
    logic [2:0]      insn_rm;
    logic [2:0]      f_frm;
    logic [4:0]      f_flags;
    logic [2:0]      eff_rm;
    logic            rm_illegal;
    logic            busy_any;

    logic [2*AW-1:0] d64_rs_addr;
    logic [127:0]    d64_rs_data;
    logic [1:0]      d64_rs_busy;
    logic            d64_wen;
    logic [AW-1:0]   d64_rd;
    logic [63:0]     d64_w_data;
    logic [2:0]      d64_frm;
    logic [4:0]      d64_flags;
    logic [2:0]      d64_eff_rm;
    logic            d64_rm_illegal;
    logic            d64_busy_any;

    logic [2*AW-1:0] odd_rs_addr;
    logic [63:0]     odd_rs_data;
    logic [1:0]      odd_rs_busy;
    logic            odd_wen;
    logic [AW-1:0]   odd_rd;
    logic [31:0]     odd_w_data;
    logic            odd_issue_en;
    logic [AW-1:0]   odd_issue_rd;
    logic [2:0]      odd_frm;
    logic [4:0]      odd_flags;
    logic [2:0]      odd_eff_rm;
    logic            odd_rm_illegal;
    logic            odd_busy_any;

    f_register_file_sb #(.FLEN(32), .NREG(32), .NRD(3)) dut (
        .clk(clk), .rst(rst), .f_rs_addr(f_rs_addr), .f_rs_data(f_rs_data),
        .f_rs_busy(f_rs_busy), .f_wen(f_wen), .f_rd(f_rd), .f_w_data(f_w_data),
        .f_flags_en(f_flags_en), .f_w_flags(f_w_flags), .f_issue_en(f_issue_en),
        .f_issue_rd(f_issue_rd), .csr_fflags_wen(csr_fflags_wen),
        .csr_fflags_wdata(csr_fflags_wdata), .csr_frm_wen(csr_frm_wen),
        .csr_frm_wdata(csr_frm_wdata), .insn_rm(insn_rm), .f_frm(f_frm),
        .f_flags(f_flags), .eff_rm(eff_rm), .rm_illegal(rm_illegal), .busy_any(busy_any)
    );

    f_register_file_sb #(.FLEN(64), .NREG(32), .NRD(2)) dut64 (
        .clk(clk), .rst(rst), .f_rs_addr(d64_rs_addr), .f_rs_data(d64_rs_data),
        .f_rs_busy(d64_rs_busy), .f_wen(d64_wen), .f_rd(d64_rd), .f_w_data(d64_w_data),
        .f_flags_en(f_flags_en), .f_w_flags(f_w_flags), .f_issue_en(f_issue_en),
        .f_issue_rd(f_issue_rd), .csr_fflags_wen(csr_fflags_wen),
        .csr_fflags_wdata(csr_fflags_wdata), .csr_frm_wen(csr_frm_wen),
        .csr_frm_wdata(csr_frm_wdata), .insn_rm(insn_rm), .f_frm(d64_frm),
        .f_flags(d64_flags), .eff_rm(d64_eff_rm), .rm_illegal(d64_rm_illegal),
        .busy_any(d64_busy_any)
    );

    f_register_file_sb #(.FLEN(32), .NREG(20), .NRD(2)) dut_odd (
        .clk(clk), .rst(rst), .f_rs_addr(odd_rs_addr), .f_rs_data(odd_rs_data),
        .f_rs_busy(odd_rs_busy), .f_wen(odd_wen), .f_rd(odd_rd), .f_w_data(odd_w_data),
        .f_flags_en(f_flags_en), .f_w_flags(f_w_flags), .f_issue_en(odd_issue_en),
        .f_issue_rd(odd_issue_rd), .csr_fflags_wen(csr_fflags_wen),
        .csr_fflags_wdata(csr_fflags_wdata), .csr_frm_wen(csr_frm_wen),
        .csr_frm_wdata(csr_frm_wdata), .insn_rm(insn_rm), .f_frm(odd_frm),
        .f_flags(odd_flags), .eff_rm(odd_eff_rm), .rm_illegal(odd_rm_illegal),
        .busy_any(odd_busy_any)
    );

`ifdef F_REGISTER_FILE_BYPASS_EN
    localparam bit BYPASS_ON = 1'b1;
`else
    localparam bit BYPASS_ON = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0:  return 64'(f_rs_data[31:0]);
            1:  return 64'(f_rs_data[63:32]);
            2:  return 64'(f_rs_data[95:64]);
            3:  return 64'(f_rs_busy[0]);
            4:  return 64'(f_rs_busy[1]);
            5:  return 64'(f_rs_busy[2]);
            6:  return 64'(f_flags);
            7:  return 64'(f_frm);
            8:  return 64'(eff_rm);
            9:  return 64'(rm_illegal);
            10: return 64'(busy_any);
            11: return d64_rs_data[63:0];
            12: return d64_rs_data[127:64];
            13: return 64'(odd_rs_data[31:0]);
            14: return 64'(odd_rs_data[63:32]);
            15: return 64'(odd_busy_any);
            16: return 64'(odd_rs_busy[1]);
            17: return 64'(d64_busy_any);
            default: return '1;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
        sb_q.push_back('{tag, sel, exp});
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_wen = 1'b0; f_issue_en = 1'b0; f_flags_en = 1'b0;
        csr_fflags_wen = 1'b0; csr_frm_wen = 1'b0;
        d64_wen = 1'b0; odd_wen = 1'b0; odd_issue_en = 1'b0;
    endtask

    task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        f_rs_addr = {a2, a1, a0};
    endtask

    initial begin
        idle();
        f_rd = '0; f_w_data = '0; f_w_flags = '0; f_issue_rd = '0;
        csr_fflags_wdata = '0; csr_frm_wdata = '0; insn_rm = 3'd0;
        d64_rd = '0; d64_w_data = '0; d64_rs_addr = '0;
        odd_rd = '0; odd_w_data = '0; odd_issue_rd = '0; odd_rs_addr = '0;
        set_addr(5'd5, 5'd5, 5'd0);

        // reset overrides every same-cycle write, issue, flag and CSR update
        rst = 1'b1;
        f_wen = 1'b1; f_rd = 5'd5; f_w_data = 32'h3F800000;
        f_issue_en = 1'b1; f_issue_rd = 5'd5;
        f_flags_en = 1'b1; f_w_flags = 5'b11111;
        csr_fflags_wen = 1'b1; csr_fflags_wdata = 5'b11111;
        csr_frm_wen = 1'b1; csr_frm_wdata = 3'd3;
        d64_wen = 1'b1; d64_rd = 5'd31; d64_w_data = 64'h1;
        odd_wen = 1'b1; odd_rd = 5'd4; odd_w_data = 32'h1;
        d64_rs_addr = {5'd31, 5'd31};
        tick();
        rst = 1'b0;
        idle();
        expect_val("rst_data0", 0, 64'h0);
        expect_val("rst_data1", 1, 64'h0);
        expect_val("rst_data2", 2, 64'h0);
        expect_val("rst_flags", 6, 64'h0);
        expect_val("rst_frm", 7, 64'h0);
        expect_val("rst_busy_any", 10, 64'h0);
        expect_val("rst_d64_data", 11, 64'h0);
        expect_val("rst_d64_busy_any", 17, 64'h0);
        expect_val("rst_eff_rm", 8, 64'h0);
        drain();

        // write f3, with a same-cycle read of address 3 on every port
        set_addr(5'd3, 5'd3, 5'd3);
        f_wen = 1'b1; f_rd = 5'd3; f_w_data = 32'h40490FDB;
        for (int p = 0; p < 3; p++)
            expect_val($sformatf("same_cyc_p%0d", p), p, BYPASS_ON ? 64'h40490FDB : 64'h0);
        drain();
        tick();
        idle();
        for (int p = 0; p < 3; p++)
            expect_val($sformatf("wr_f3_p%0d", p), p, 64'h40490FDB);
        drain();

        // per-port independence of same-cycle forwarding
        set_addr(5'd10, 5'd3, 5'd10);
        f_wen = 1'b1; f_rd = 5'd10; f_w_data = 32'hA5A5A5A5;
        expect_val("byp_p0", 0, BYPASS_ON ? 64'hA5A5A5A5 : 64'h0);
        expect_val("byp_p1_other", 1, 64'h40490FDB);
        expect_val("byp_p2", 2, BYPASS_ON ? 64'hA5A5A5A5 : 64'h0);
        drain();
        tick();
        idle();

        // register 0 is an ordinary writable register
        f_wen = 1'b1; f_rd = 5'd0; f_w_data = 32'h12345678;
        tick();
        idle();
        set_addr(5'd10, 5'd3, 5'd0);
        expect_val("f0_p2", 2, 64'h12345678);
        expect_val("f10_p0", 0, 64'hA5A5A5A5);
        drain();

        // scoreboard: issue rd=7 at cycle 0; busy is not forwarded within the cycle
        set_addr(5'd7, 5'd7, 5'd7);
        f_issue_en = 1'b1; f_issue_rd = 5'd7;
        expect_val("busy_same_cycle", 3, 64'h0);
        drain();
        tick();
        idle();
        for (int p = 0; p < 3; p++)
            expect_val($sformatf("busy_c1_p%0d", p), 3 + p, 64'h1);
        expect_val("busy_any_c1", 10, 64'h1);
        drain();
        tick(); tick(); tick();
        expect_val("busy_c4", 3, 64'h1);
        drain();
        // cycle 4: writeback and issue to the same register, so the issue wins
        f_wen = 1'b1; f_rd = 5'd7; f_w_data = 32'h0000BEEF;
        f_issue_en = 1'b1; f_issue_rd = 5'd7;
        tick();
        idle();
        expect_val("busy_c5_issue_wins", 3, 64'h1);
        drain();
        tick();
        // cycle 6: writeback alone
        f_wen = 1'b1; f_rd = 5'd7; f_w_data = 32'h0000CAFE;
        tick();
        idle();
        expect_val("busy_c7_cleared", 3, 64'h0);
        expect_val("busy_any_c7", 10, 64'h0);
        expect_val("f7_data", 1, 64'h0000CAFE);
        drain();

        // pending bits are per register; writeback to a non-pending register is legal
        set_addr(5'd9, 5'd7, 5'd9);
        f_issue_en = 1'b1; f_issue_rd = 5'd9;
        tick();
        idle();
        expect_val("busy9_p0", 3, 64'h1);
        expect_val("busy7_p1", 4, 64'h0);
        expect_val("busy9_p2", 5, 64'h1);
        drain();
        set_addr(5'd9, 5'd8, 5'd9);
        f_wen = 1'b1; f_rd = 5'd8; f_w_data = 32'h8;
        tick();
        idle();
        expect_val("busy8_nonpend", 4, 64'h0);
        expect_val("busy9_kept", 3, 64'h1);
        drain();
        f_wen = 1'b1; f_rd = 5'd9; f_w_data = 32'h9;
        tick();
        idle();
        expect_val("busy_any_done", 10, 64'h0);
        drain();

        // fflags are accrued and sticky
        f_flags_en = 1'b1; f_w_flags = 5'b00001;
        tick();
        f_w_flags = 5'b10000;
        tick();
        idle();
        expect_val("flags_accrue", 6, 64'h11);
        drain();
        tick();
        expect_val("flags_sticky", 6, 64'h11);
        drain();
        // a CSR write and a same-cycle accrual combine
        csr_fflags_wen = 1'b1; csr_fflags_wdata = 5'b00000;
        f_flags_en = 1'b1; f_w_flags = 5'b00100;
        tick();
        idle();
        expect_val("flags_csr_plus_accrue", 6, 64'h04);
        drain();
        csr_fflags_wen = 1'b1; csr_fflags_wdata = 5'b01010;
        tick();
        idle();
        expect_val("flags_csr_only", 6, 64'h0A);
        drain();

        // rounding-mode resolution
        csr_frm_wen = 1'b1; csr_frm_wdata = 3'b010;
        tick();
        idle();
        insn_rm = 3'd7;
        expect_val("frm_2", 7, 64'h2);
        expect_val("eff_dyn2", 8, 64'h2);
        expect_val("ill_dyn2", 9, 64'h0);
        drain();
        for (int r = 0; r < 7; r++) begin
            insn_rm = 3'(r);
            expect_val($sformatf("eff_static%0d", r), 8, 64'(r));
            expect_val($sformatf("ill_static%0d", r), 9, (r >= 5) ? 64'h1 : 64'h0);
            drain();
        end
        for (int f = 4; f < 8; f++) begin
            csr_frm_wen = 1'b1; csr_frm_wdata = 3'(f);
            insn_rm = 3'd7;
            tick();
            idle();
            expect_val($sformatf("frm_store%0d", f), 7, 64'(f));
            expect_val($sformatf("eff_dyn%0d", f), 8, 64'(f));
            expect_val($sformatf("ill_dyn%0d", f), 9, (f >= 5) ? 64'h1 : 64'h0);
            drain();
        end

        // 64-bit, 2-port instance: full-width readback on both ports
        d64_wen = 1'b1; d64_rd = 5'd31; d64_w_data = 64'hFFFFFFFF3F800000;
        tick();
        idle();
        d64_rs_addr = {5'd31, 5'd31};
        expect_val("d64_p0", 11, 64'hFFFFFFFF3F800000);
        expect_val("d64_p1", 12, 64'hFFFFFFFF3F800000);
        drain();

        // 20-register instance: addresses >= NREG are ignored and read as 0
        odd_wen = 1'b1; odd_rd = 5'd19; odd_w_data = 32'hCAFEF00D;
        tick();
        odd_wen = 1'b1; odd_rd = 5'd25; odd_w_data = 32'hDEADBEEF;
        odd_issue_en = 1'b1; odd_issue_rd = 5'd25;
        tick();
        idle();
        odd_rs_addr = {5'd25, 5'd19};
        expect_val("odd_last_reg", 13, 64'hCAFEF00D);
        expect_val("odd_oob_data", 14, 64'h0);
        expect_val("odd_oob_busy", 16, 64'h0);
        expect_val("odd_oob_busy_any", 15, 64'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/f_register_file_sb.md
Name: f_register_file_sb

Overview:
- Parametrised floating-point register file for the FPU with a configurable number of read ports, for example 3 for fused multiply-add rs3.
- Adds a per-register pending scoreboard for multi-cycle FP ops, sticky accrued exception flags (fflags), the frm CSR, and rounding-mode resolution.
- Sits between FPU decode/issue (cu), the FP execute pipeline and the CSR unit.

Parameters:
- FLEN, 32, register data width in bits (32 or 64).
- NREG, 32, number of FP registers; address width AW = $clog2(NREG).
- NRD, 3, number of combinational read ports.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- f_rs_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- f_rs_data  out  NRD*FLEN  packed read data
- f_rs_busy  out  NRD  pending bit of each addressed register
- f_wen  in  1  writeback enable
- f_rd  in  AW  writeback destination
- f_w_data  in  FLEN  writeback data
- f_flags_en  in  1  accrue f_w_flags this cycle
- f_w_flags  in  5  {NV,DZ,OF,UF,NX} from the completing op
- f_issue_en  in  1  a multi-cycle op issues to f_issue_rd
- f_issue_rd  in  AW  destination of the issuing op
- csr_fflags_wen  in  1  CSR write to fflags
- csr_fflags_wdata  in  5  CSR fflags write data
- csr_frm_wen  in  1  CSR write to frm
- csr_frm_wdata  in  3  CSR frm write data
- insn_rm  in  3  rm field of the current instruction
- f_frm  out  3  current frm
- f_flags  out  5  current accrued fflags
- eff_rm  out  3  resolved rounding mode
- rm_illegal  out  1  resolved rounding mode is reserved
- busy_any  out  1  OR of all pending bits

Behaviour:
- Reset, synchronous, active-high:
  - all NREG registers, the pending vector, f_frm and f_flags clear to 0 at the clock edge where rst=1.
  - rst overrides every same-cycle write, issue, CSR write and flag accrual.
- Registers:
  - all registers are writable; register 0 is not hardwired to zero.
  - write takes effect at the posedge when f_wen=1.
  - reads are combinational, zero latency.
- Pending scoreboard:
  - f_issue_en sets pending[f_issue_rd] at the next edge.
  - f_wen clears pending[f_rd] at the next edge.
  - issue and writeback to the same register in the same cycle leaves pending set (issue wins).
  - issue to an already-pending register: bit stays set, no error.
  - writeback to a non-pending register: legal, bit stays clear.
  - f_rs_busy[i] = pending[f_rs_addr[i]] using registered state; it is not bypassed.
- fflags:
  - next = (csr_fflags_wen ? csr_fflags_wdata : f_flags) | (f_flags_en ? f_w_flags : 0).
  - a same-cycle CSR write does not lose hardware-accrued flags.
  - flags are sticky; only a CSR write or reset clears them.
- frm:
  - loads csr_frm_wdata on csr_frm_wen.
  - all 8 encodings are stored as written.
- Rounding-mode resolution (combinational):
  - eff_rm = (insn_rm==3'b111) ? f_frm : insn_rm.
  - rm_illegal = (eff_rm==5) | (eff_rm==6) | (eff_rm==7).
  - covers a reserved static rm and also a dynamic rm whose frm holds 5, 6 or 7.
- Ports are bit-identical in function for all i < NRD.
- Addresses ≥ NREG, when NREG is not a power of 2: reads return 0 and busy 0; writes and issues are ignored.

Optional Feature:
- Macro F_REGISTER_FILE_BYPASS_EN.
- Defined:
  - a read port whose address equals f_rd while f_wen=1 returns f_w_data in the same cycle.
  - with multiple matching ports, each is bypassed independently.
- Undefined: the read returns the pre-write register value; the new value is visible the cycle after.
- Pending/busy is never bypassed in either build.

Test Plan:
- Assert rst with f_wen=1, f_rd=5, f_w_data=32'h3F800000 -> next cycle every f_rs_data=0, f_flags=0, f_frm=0, busy_any=0.
- Write f3=32'h40490FDB; read ports 0..2 all at addr 3 -> all return 40490FDB next cycle. With the bypass macro, the same-cycle read of 3 during the write also returns 40490FDB; without it, the same-cycle read returns 0.
- Scoreboard, where "cycle N" is the cycle in which inputs are driven:
  - issue rd=7 at cycle 0 -> f_rs_busy=1 for addr 7 from cycle 1.
  - writeback rd=7 with issue rd=7 at cycle 4 -> still busy at cycle 5.
  - writeback alone at cycle 6 -> busy clears at cycle 7.
- Flags:
  - f_flags_en with flags=5'b00001, then 5'b10000 -> f_flags=5'b10001.
  - csr_fflags_wen with data 0 plus same-cycle accrual of 5'b00100 -> f_flags=5'b00100.
- Rounding mode:
  - csr frm=3'b010; insn_rm=7 -> eff_rm=2, rm_illegal=0.
  - insn_rm=5 -> rm_illegal=1.
  - frm=6 with insn_rm=7 -> eff_rm=6, rm_illegal=1.
- NRD=2, FLEN=64: write f31=64'hFFFFFFFF3F800000 -> 64-bit readback exact on both ports.
